// File: rtl/mux_ff_scan.sv
// Registered N:1 multiplexer with manual select or round-robin scan; every sample carries its channel index and valid.
// Define MUX_FF_SKIP_EN to make scan mode skip channels whose in_vld is low.
module mux_ff_scan #(
  parameter int W = 8,
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_vld,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  input  logic             hold,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_ch,
  output logic             out_vld
);

  logic [SW-1:0] ptr;

  logic [W-1:0]  sel_data;
  logic          sel_vld;
  logic          sel_ok;

  logic [SW-1:0] scan_idx;
  logic          scan_go;
  logic [W-1:0]  scan_data;
  logic          scan_vld;

  function automatic logic [SW-1:0] inc(input logic [SW-1:0] x);
    return (x == SW'(N - 1)) ? '0 : x + 1'b1;
  endfunction

  // Decode by comparison rather than indexing so sel >= N (non power-of-two N) stays in range.
  always_comb begin
    sel_data = '0;
    sel_vld  = 1'b0;
    sel_ok   = 1'b0;
    for (int unsigned c = 0; c < N; c++) begin
      if (sel == SW'(c)) begin
        sel_data = in_data[c*W +: W];
        sel_vld  = in_vld[c];
        sel_ok   = 1'b1;
      end
    end
  end

`ifdef MUX_FF_SKIP_EN
  logic [2*N-1:0] vld_rot;
  int unsigned    pos;

  // Rotate so bit 0 is the channel at ptr; the lowest set bit is the next valid channel.
  always_comb begin
    vld_rot  = {in_vld, in_vld} >> ptr;
    scan_go  = 1'b0;
    scan_idx = ptr;
    pos      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!scan_go && vld_rot[i]) begin
        scan_go = 1'b1;
        pos     = 32'(ptr) + i;
        if (pos >= 32'(N)) pos = pos - 32'(N);
        scan_idx = SW'(pos);
      end
    end
  end
`else
  always_comb begin
    scan_idx = ptr;
    scan_go  = 1'b1;
  end
`endif

  always_comb begin
    scan_data = '0;
    scan_vld  = 1'b0;
    for (int unsigned c = 0; c < N; c++) begin
      if (scan_idx == SW'(c)) begin
        scan_data = in_data[c*W +: W];
        scan_vld  = in_vld[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      out_data <= '0;
      out_ch   <= '0;
      out_vld  <= 1'b0;
    end else if (!hold) begin
      if (!mode) begin
        out_ch <= sel;
        if (sel_ok) begin
          out_data <= sel_data;
          out_vld  <= sel_vld;
          ptr      <= inc(sel);
        end else begin
          out_data <= '0;
          out_vld  <= 1'b0;
        end
      end else if (scan_go) begin
        out_data <= scan_data;
        out_ch   <= scan_idx;
        out_vld  <= scan_vld;
        ptr      <= inc(scan_idx);
      end else begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_ff_scan.sv
// Directed scoreboard bench for mux_ff_scan: a N=4/W=8 instance and an odd N=5/W=4 instance.
module tb_mux_ff_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_mode, a_hold;
  logic [31:0] a_in_data;
  logic [3:0]  a_in_vld;
  logic [1:0]  a_sel;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_ch;
  logic        a_out_vld;

  logic        b_rst, b_mode, b_hold;
  logic [19:0] b_in_data;
  logic [4:0]  b_in_vld;
  logic [2:0]  b_sel;
  logic [3:0]  b_out_data;
  logic [2:0]  b_out_ch;
  logic        b_out_vld;

  mux_ff_scan #(.W(8), .N(4)) dut_a (
    .clk(clk), .rst(a_rst), .in_data(a_in_data), .in_vld(a_in_vld), .mode(a_mode),
    .sel(a_sel), .hold(a_hold), .out_data(a_out_data), .out_ch(a_out_ch), .out_vld(a_out_vld)
  );

  mux_ff_scan #(.W(4), .N(5)) dut_b (
    .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_vld(b_in_vld), .mode(b_mode),
    .sel(b_sel), .hold(b_hold), .out_data(b_out_data), .out_ch(b_out_ch), .out_vld(b_out_vld)
  );

  typedef struct {
    string      tag;
    logic [7:0] data;
    logic [2:0] ch;
    logic       vld;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input string what, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: got %h expected %h", tag, what, obs, exp);
    end
  endtask

  task automatic tick_a(input string tag, input logic [7:0] d, input logic [2:0] c, input logic v);
    exp_t e;
    e.tag = tag; e.data = d; e.ch = c; e.vld = v;
    qa.push_back(e);
    @(posedge clk);
    #1;
    e = qa.pop_front();
    chk(e.tag, "data", a_out_data, e.data);
    chk(e.tag, "ch", 8'(a_out_ch), 8'(e.ch));
    chk(e.tag, "vld", 8'(a_out_vld), 8'(e.vld));
  endtask

  task automatic tick_b(input string tag, input logic [7:0] d, input logic [2:0] c, input logic v);
    exp_t e;
    e.tag = tag; e.data = d; e.ch = c; e.vld = v;
    qb.push_back(e);
    @(posedge clk);
    #1;
    e = qb.pop_front();
    chk(e.tag, "data", 8'(b_out_data), e.data);
    chk(e.tag, "ch", 8'(b_out_ch), 8'(e.ch));
    chk(e.tag, "vld", 8'(b_out_vld), 8'(e.vld));
  endtask

  initial begin
    a_rst = 1'b1; a_mode = 1'b0; a_hold = 1'b0; a_sel = 2'd2;
    a_in_data = 32'h4433_2211; a_in_vld = 4'b1111;
    b_rst = 1'b1; b_mode = 1'b0; b_hold = 1'b0; b_sel = 3'd0;
    b_in_data = 20'h54321; b_in_vld = 5'b11111;

    // reset
    tick_a("rst0", 8'h00, 3'd0, 1'b0);
    tick_a("rst1", 8'h00, 3'd0, 1'b0);
    a_rst = 1'b0; a_mode = 1'b1;
    tick_a("rst_first_scan", 8'h11, 3'd0, 1'b1);

    // manual
    a_mode = 1'b0;
    a_sel = 2'd0; tick_a("man0", 8'h11, 3'd0, 1'b1);
    a_sel = 2'd1; tick_a("man1", 8'h22, 3'd1, 1'b1);
    a_sel = 2'd2; tick_a("man2", 8'h33, 3'd2, 1'b1);
    a_sel = 2'd3; tick_a("man3", 8'h44, 3'd3, 1'b1);

    // scan wrap, resuming after sel=3
    a_mode = 1'b1;
    tick_a("scan0", 8'h11, 3'd0, 1'b1);
    tick_a("scan1", 8'h22, 3'd1, 1'b1);
    tick_a("scan2", 8'h33, 3'd2, 1'b1);
    tick_a("scan3", 8'h44, 3'd3, 1'b1);
    tick_a("scan4", 8'h11, 3'd0, 1'b1);
    tick_a("scan5", 8'h22, 3'd1, 1'b1);
`ifndef MUX_FF_SKIP_EN
    a_in_vld = 4'b0101;
    tick_a("scanv2", 8'h33, 3'd2, 1'b1);
    tick_a("scanv3", 8'h44, 3'd3, 1'b0);
    tick_a("scanv0", 8'h11, 3'd0, 1'b1);
    tick_a("scanv1", 8'h22, 3'd1, 1'b0);
    a_in_vld = 4'b1111;
`endif

    // hold and mode switch
    a_mode = 1'b0; a_sel = 2'd2;
    tick_a("hold_pre", 8'h33, 3'd2, 1'b1);
    a_mode = 1'b1; a_hold = 1'b1; a_in_data = 32'hDDCC_BBAA; a_in_vld = 4'b0000; a_sel = 2'd0;
    tick_a("hold0", 8'h33, 3'd2, 1'b1);
    tick_a("hold1", 8'h33, 3'd2, 1'b1);
    tick_a("hold2", 8'h33, 3'd2, 1'b1);
    a_hold = 1'b0; a_in_data = 32'h4433_2211; a_in_vld = 4'b1111;
    tick_a("hold_rel0", 8'h44, 3'd3, 1'b1);
    tick_a("hold_rel1", 8'h11, 3'd0, 1'b1);

    // reset mid-scan
    a_rst = 1'b1;
    tick_a("rst_mid", 8'h00, 3'd0, 1'b0);
    a_rst = 1'b0;
    tick_a("rst_mid_scan", 8'h11, 3'd0, 1'b1);

`ifdef MUX_FF_SKIP_EN
    a_rst = 1'b1;
    tick_a("skip_rst", 8'h00, 3'd0, 1'b0);
    a_rst = 1'b0; a_in_vld = 4'b1010;
    tick_a("skip0", 8'h22, 3'd1, 1'b1);
    tick_a("skip1", 8'h44, 3'd3, 1'b1);
    tick_a("skip2", 8'h22, 3'd1, 1'b1);
    tick_a("skip3", 8'h44, 3'd3, 1'b1);
    a_in_vld = 4'b0000;
    tick_a("skip_none", 8'h44, 3'd3, 1'b0);
    a_in_vld = 4'b0100;
    tick_a("skip_ch2", 8'h33, 3'd2, 1'b1);
`endif

    // odd N
    tick_b("b_rst", 8'h00, 3'd0, 1'b0);
    b_rst = 1'b0; b_sel = 3'd1;
    tick_b("b_man1", 8'h02, 3'd1, 1'b1);
    b_sel = 3'd6;
    tick_b("b_sel6", 8'h00, 3'd6, 1'b0);
    b_mode = 1'b1;
    tick_b("b_scan2", 8'h03, 3'd2, 1'b1);
    tick_b("b_scan3", 8'h04, 3'd3, 1'b1);
    tick_b("b_scan4", 8'h05, 3'd4, 1'b1);
    tick_b("b_scan0", 8'h01, 3'd0, 1'b1);
    b_mode = 1'b0; b_sel = 3'd4;
    tick_b("b_man4", 8'h05, 3'd4, 1'b1);
    b_sel = 3'd7;
    tick_b("b_sel7", 8'h00, 3'd7, 1'b0);
    b_mode = 1'b1;
    tick_b("b_wrap0", 8'h01, 3'd0, 1'b1);
    tick_b("b_wrap1", 8'h02, 3'd1, 1'b1);
    b_rst = 1'b1;
    tick_b("b_rst_mid", 8'h00, 3'd0, 1'b0);
    b_rst = 1'b0;
    tick_b("b_after_rst", 8'h01, 3'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
